tcp_conn: RTL
=============

TCP_CONN -- requirements
Module: tcp_conn

Interface
REQ-001 Parameter SEQ_W, 32, sequence/ack number width.
REQ-002 Parameter SIZE_W, 16, payload size width.
REQ-003 Parameter FLAG_W, 8, flags width; bit index CWR0 ECE1 URG2 ACK3 PSH4 RST5 SYN6 FIN7.
REQ-004 Parameter TO_W, 16, timer width.
REQ-005 Parameter TO_CYCLES, 1000, retransmit timeout in cycles.
REQ-006 Parameter TW_CYCLES, 2000, TIME_WAIT duration in cycles.
REQ-007 Parameter MAX_RETRY, 3, retransmissions before give-up.
REQ-008 clk  in  1  single clock; one clock domain, all logic on rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 open_v_i  in  1; open_seq_i  in  SEQ_W; open request, initial sequence number.
REQ-011 close_v_i  in  1  active close request; abort_v_i  in  1  silent drop to CLOSED.
REQ-012 rec_v_i  in  1; rec_size_i  SIZE_W; rec_seq_i, rec_ack_i  SEQ_W; rec_flag_i  FLAG_W; validated received header.
REQ-013 sent_v_i  in  1; send_size_i  in  SIZE_W; current header transmitted with given payload bytes.
REQ-014 valid_o  out  1  state != CLOSED; est_o  out  1  state == EST; state_o  out  4  state encoding.
REQ-015 force_send_v_o  out  1; send_flag_o  FLAG_W; send_seq_o, send_ack_o  SEQ_W; next header.
REQ-016 err_o  out  1  one-cycle pulse on RST received or retry exhaustion.

Function
REQ-017 States (state_o): CLOSED0 SYN_WAIT1 SYN_SENT2 ACK_WAIT3 EST4 FIN_WAIT5 FIN_WAIT_1 6 FIN_WAIT_2 7 TIME_WAIT8; encodings 9-15 unreachable.
REQ-018 Event priority: abort_v_i > rec RST > timer expiry > all other transitions.
REQ-019 CLOSED + open_v_i -> SYN_WAIT; seq_q<=open_seq_i, ack_q<=0, retry<=0, peer_fin<=0; open_v_i ignored outside CLOSED.
REQ-020 SYN_WAIT: flag SYN, force_send 1; sent_v_i -> SYN_SENT, seq_q unchanged.
REQ-021 SYN_SENT: rec SYN&ACK with rec_ack_i==seq_q+1 -> ACK_WAIT, seq_q<=seq_q+1, ack_q<=rec_seq_i+1; other rec ignored.
REQ-022 ACK_WAIT: flag ACK, force_send 1; sent_v_i -> EST.
REQ-023 EST: rec with rec_seq_i==ack_q -> ack_q+=rec_size_i; any rec sets ack_pend; mismatched seq leaves ack_q (duplicate ACK).
REQ-024 EST rec FIN (seq match) -> ack_q+=rec_size_i+1, peer_fin<=1, -> FIN_WAIT.
REQ-025 EST close_v_i -> FIN_WAIT; close_v_i ignored in other states.
REQ-026 FIN_WAIT: flag FIN|ACK, force_send 1; sent_v_i -> FIN_WAIT_1, seq_q+=send_size_i.
REQ-027 FIN_WAIT_1: rec ACK with rec_ack_i==seq_q+1 -> seq_q+=1; then peer_fin -> CLOSED; else rec FIN -> TIME_WAIT, ack_q+=rec_size_i+1; else -> FIN_WAIT_2.
REQ-028 FIN_WAIT_2: rec FIN -> TIME_WAIT, ack_q+=rec_size_i+1, ack_pend<=1.
REQ-029 TIME_WAIT: flag ACK; timer reaching TW_CYCLES-1 -> CLOSED.
REQ-030 Flags: CLOSED 0; SYN_WAIT 0x40; FIN_WAIT 0x88; all other states 0x08.
REQ-031 force_send_v_o = SYN_WAIT|ACK_WAIT|FIN_WAIT|ack_pend; ack_pend cleared by sent_v_i, set-wins if rec_v_i same cycle.
REQ-032 EST/FIN_WAIT_2/TIME_WAIT sent_v_i: seq_q+=send_size_i; all adds modulo 2^SEQ_W, carry dropped.
REQ-033 Timer cleared on entry to SYN_SENT, FIN_WAIT_1, TIME_WAIT; increments each cycle there; saturates, no wrap.
REQ-034 Timer == TO_CYCLES-1 in SYN_SENT/FIN_WAIT_1: retry<MAX_RETRY -> retry+=1, back to SYN_WAIT/FIN_WAIT; else -> CLOSED, err_o pulse.
REQ-035 rec RST in any non-CLOSED state -> CLOSED, err_o pulse; abort_v_i -> CLOSED, no err_o.
REQ-036 send_seq_o=seq_q, send_ack_o=ack_q, registered; valid in every state.

Reset
REQ-037 reset asserted: state CLOSED, seq_q/ack_q/timer/retry/ack_pend/peer_fin 0, all outputs 0, effective immediately, mid-operation included.

Verification
REQ-038 open(seq 0x100), sent, rec SYN|ACK seq 0x500 ack 0x101, sent -> EST, send_seq 0x101, send_ack 0x501.
REQ-039 EST rec 20 B seq==ack -> ack+20, force_send 1 until sent_v_i; wrong seq -> ack unchanged, force_send 1.
REQ-040 SYN_SENT no reply, MAX_RETRY=3 -> 3 SYN_WAIT re-entries at TO_CYCLES spacing, then CLOSED, err_o one cycle.
REQ-041 close, sent, rec ACK, rec FIN -> TIME_WAIT; CLOSED exactly TW_CYCLES after entry; seq at 0xFFFFFFFF+1 wraps 0.
REQ-042 EST rec RST with abort_v_i same cycle -> CLOSED, err_o 0; reset in FIN_WAIT_2 -> all outputs 0.

Source files
------------

// File: rtl/tcp_conn.sv
// Single-connection TCP control FSM: handshake, data ack tracking, active/passive close,
// retransmit timeout with bounded retries, and TIME_WAIT.
module tcp_conn #(
  parameter int unsigned SEQ_W     = 32,
  parameter int unsigned SIZE_W    = 16,
  parameter int unsigned FLAG_W    = 8,
  parameter int unsigned TO_W      = 16,
  parameter int unsigned TO_CYCLES = 1000,
  parameter int unsigned TW_CYCLES = 2000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              open_v_i,
  input  logic [SEQ_W-1:0]  open_seq_i,
  input  logic              close_v_i,
  input  logic              abort_v_i,
  input  logic              rec_v_i,
  input  logic [SIZE_W-1:0] rec_size_i,
  input  logic [SEQ_W-1:0]  rec_seq_i,
  input  logic [SEQ_W-1:0]  rec_ack_i,
  input  logic [FLAG_W-1:0] rec_flag_i,
  input  logic              sent_v_i,
  input  logic [SIZE_W-1:0] send_size_i,
  output logic              valid_o,
  output logic              est_o,
  output logic [3:0]        state_o,
  output logic              force_send_v_o,
  output logic [FLAG_W-1:0] send_flag_o,
  output logic [SEQ_W-1:0]  send_seq_o,
  output logic [SEQ_W-1:0]  send_ack_o,
  output logic              err_o
);

  localparam logic [3:0] CLOSED     = 4'd0;
  localparam logic [3:0] SYN_WAIT   = 4'd1;
  localparam logic [3:0] SYN_SENT   = 4'd2;
  localparam logic [3:0] ACK_WAIT   = 4'd3;
  localparam logic [3:0] EST        = 4'd4;
  localparam logic [3:0] FIN_WAIT   = 4'd5;
  localparam logic [3:0] FIN_WAIT_1 = 4'd6;
  localparam logic [3:0] FIN_WAIT_2 = 4'd7;
  localparam logic [3:0] TIME_WAIT  = 4'd8;

  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);

  logic [3:0]         state_q, state_d;
  logic [SEQ_W-1:0]   seq_q, seq_d, ack_q, ack_d;
  logic [TO_W-1:0]    timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               ack_pend_q, ack_pend_d;
  logic               peer_fin_q, peer_fin_d;
  logic               err_q, err_d;

  logic f_ack, f_rst, f_syn, f_fin, timed, to_hit, tw_hit;
  logic [SEQ_W-1:0] rec_size_ext, send_size_ext;
  logic unused_flags;

  assign f_ack = rec_flag_i[3];
  assign f_rst = rec_flag_i[5];
  assign f_syn = rec_flag_i[6];
  assign f_fin = rec_flag_i[7];
  assign unused_flags = ^{rec_flag_i[4], rec_flag_i[2:0]};

  assign rec_size_ext  = SEQ_W'(rec_size_i);
  assign send_size_ext = SEQ_W'(send_size_i);

  assign timed  = (state_q == SYN_SENT) || (state_q == FIN_WAIT_1) || (state_q == TIME_WAIT);
  assign to_hit = (timer_q == TO_W'(TO_CYCLES - 1));
  assign tw_hit = (timer_q == TO_W'(TW_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    ack_d      = ack_q;
    retry_d    = retry_q;
    peer_fin_d = peer_fin_q;
    ack_pend_d = ack_pend_q & ~sent_v_i;
    err_d      = 1'b0;

    if (abort_v_i) begin
      state_d = CLOSED;
    end else if (state_q != CLOSED && rec_v_i && f_rst) begin
      state_d = CLOSED;
      err_d   = 1'b1;
    end else if (to_hit && (state_q == SYN_SENT || state_q == FIN_WAIT_1)) begin
      if (retry_q < RETRY_W'(MAX_RETRY)) begin
        retry_d = retry_q + 1'b1;
        state_d = (state_q == SYN_SENT) ? SYN_WAIT : FIN_WAIT;
      end else begin
        state_d = CLOSED;
        err_d   = 1'b1;
      end
    end else if (tw_hit && state_q == TIME_WAIT) begin
      state_d = CLOSED;
    end else begin
      case (state_q)
        CLOSED: if (open_v_i) begin
          state_d    = SYN_WAIT;
          seq_d      = open_seq_i;
          ack_d      = '0;
          retry_d    = '0;
          peer_fin_d = 1'b0;
        end
        SYN_WAIT: if (sent_v_i) state_d = SYN_SENT;
        SYN_SENT: if (rec_v_i && f_syn && f_ack && rec_ack_i == seq_q + 1'b1) begin
          state_d = ACK_WAIT;
          seq_d   = seq_q + 1'b1;
          ack_d   = rec_seq_i + 1'b1;
        end
        ACK_WAIT: if (sent_v_i) state_d = EST;
        EST: begin
          if (sent_v_i) seq_d = seq_q + send_size_ext;
          if (rec_v_i) begin
            ack_pend_d = 1'b1;
            if (rec_seq_i == ack_q) begin
              if (f_fin) begin
                ack_d      = ack_q + rec_size_ext + 1'b1;
                peer_fin_d = 1'b1;
                state_d    = FIN_WAIT;
              end else begin
                ack_d = ack_q + rec_size_ext;
              end
            end
          end
          if (close_v_i) state_d = FIN_WAIT;
        end
        FIN_WAIT: if (sent_v_i) begin
          state_d = FIN_WAIT_1;
          seq_d   = seq_q + send_size_ext;
        end
        // Our FIN acked: a peer FIN seen earlier (or arriving now) decides the exit path
        FIN_WAIT_1: if (rec_v_i && f_ack && rec_ack_i == seq_q + 1'b1) begin
          seq_d = seq_q + 1'b1;
          if (peer_fin_q) begin
            state_d = CLOSED;
          end else if (f_fin) begin
            state_d = TIME_WAIT;
            ack_d   = ack_q + rec_size_ext + 1'b1;
          end else begin
            state_d = FIN_WAIT_2;
          end
        end
        FIN_WAIT_2: begin
          if (sent_v_i) seq_d = seq_q + send_size_ext;
          if (rec_v_i && f_fin) begin
            state_d    = TIME_WAIT;
            ack_d      = ack_q + rec_size_ext + 1'b1;
            ack_pend_d = 1'b1;
          end
        end
        TIME_WAIT: if (sent_v_i) seq_d = seq_q + send_size_ext;
        default: state_d = CLOSED;
      endcase
    end

    if (state_d == CLOSED) ack_pend_d = 1'b0;

    timer_d = timer_q;
    if (state_d != state_q)             timer_d = '0;
    else if (timed && timer_q != '1)    timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLOSED;
      seq_q      <= '0;
      ack_q      <= '0;
      timer_q    <= '0;
      retry_q    <= '0;
      ack_pend_q <= 1'b0;
      peer_fin_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      ack_q      <= ack_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      ack_pend_q <= ack_pend_d;
      peer_fin_q <= peer_fin_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    case (state_q)
      CLOSED:   send_flag_o = '0;
      SYN_WAIT: send_flag_o = FLAG_W'(8'h40);
      FIN_WAIT: send_flag_o = FLAG_W'(8'h88);
      default:  send_flag_o = FLAG_W'(8'h08);
    endcase
  end

  assign valid_o        = (state_q != CLOSED);
  assign est_o          = (state_q == EST);
  assign state_o        = state_q;
  assign force_send_v_o = (state_q == SYN_WAIT) || (state_q == ACK_WAIT) ||
                          (state_q == FIN_WAIT) || ack_pend_q;
  assign send_seq_o     = seq_q;
  assign send_ack_o     = ack_q;
  assign err_o          = err_q;

endmodule
